// File: rtl/cm_sort_ser_if.sv
// Bus between cm_sort_ser and its environment: sorted-vector capture side plus
// the valid/ready element stream. Signal names are from the serializer's view.
interface cm_sort_ser_if #(
  parameter int unsigned DCNT   = 4,
  parameter int unsigned DWIDTH = 16
);
  localparam int unsigned IDX_WIDTH = $clog2(DCNT);

  logic                                i_vld;
  logic [DCNT-1:0][DWIDTH-1:0]         i_data;
  logic [DCNT-1:0][IDX_WIDTH-1:0]      i_idx;
  logic                                o_vld;
  logic                                i_rdy;
  logic [DWIDTH-1:0]                   o_data;
  logic [IDX_WIDTH-1:0]                o_idx;
  logic                                o_last;

  modport master (
    output i_vld, i_data, i_idx, i_rdy,
    input  o_vld, o_data, o_idx, o_last
  );

  modport slave (
    input  i_vld, i_data, i_idx, i_rdy,
    output o_vld, o_data, o_idx, o_last
  );
endinterface

// File: rtl/cm_sort_ser.sv
// Two-slot vector buffer that replays each sorted vector from cm_sort as a
// valid/ready element stream, flagging vectors dropped while full.
module cm_sort_ser #(
  parameter int unsigned DCNT   = 4,
  parameter int unsigned DWIDTH = 16,
  localparam int unsigned IDX_WIDTH = $clog2(DCNT)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  cm_sort_ser_if.slave bus,
  output logic [1:0]   o_fill,
  output logic         o_ovf
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(DCNT - 1);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } fill_e;

  fill_e                          r_fill, w_fill_d;
  logic                           r_wp, w_wp_d;
  logic                           r_rp, w_rp_d;
  logic [IDX_WIDTH-1:0]           r_ecnt, w_ecnt_d;
  logic                           r_ovf, w_ovf_d;
  logic [DCNT-1:0][DWIDTH-1:0]    r_slot_data [2];
  logic [DCNT-1:0][IDX_WIDTH-1:0] r_slot_idx  [2];

  logic w_vld, w_last, w_xfer, w_release, w_capture, w_drop;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fill <= StEmpty;
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_ecnt <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_fill <= w_fill_d;
      r_wp   <= w_wp_d;
      r_rp   <= w_rp_d;
      r_ecnt <= w_ecnt_d;
      r_ovf  <= w_ovf_d;
    end
  end

  // Slot storage carries no reset; contents are only observed while o_vld is high.
  always_ff @(posedge i_clk) begin
    if (w_capture && !i_rst) begin
      r_slot_data[r_wp] <= bus.i_data;
      r_slot_idx[r_wp]  <= bus.i_idx;
    end
  end

  // Next-state logic
  always_comb begin
    w_xfer    = w_vld & bus.i_rdy;
    w_release = w_xfer & w_last;
    // When full, a same-cycle release frees slot[rp], which equals slot[wp].
    w_capture = bus.i_vld & ((r_fill != StFull) | w_release);
    w_drop    = bus.i_vld & (r_fill == StFull) & ~w_release;

    w_fill_d = r_fill;
    unique case ({w_capture, w_release})
      2'b10: w_fill_d = (r_fill == StEmpty) ? StOne : StFull;
      2'b01: w_fill_d = (r_fill == StFull) ? StOne : StEmpty;
      default: w_fill_d = r_fill;
    endcase

    w_ecnt_d = r_ecnt;
    if (w_release) begin
      w_ecnt_d = '0;
    end else if (w_xfer) begin
      w_ecnt_d = r_ecnt + IDX_WIDTH'(1);
    end

    w_rp_d  = r_rp ^ w_release;
    w_wp_d  = r_wp ^ w_capture;
    w_ovf_d = w_drop;
  end

  // Outputs depend on registered state only.
  always_comb begin
    w_vld       = (r_fill != StEmpty);
    w_last      = w_vld & (r_ecnt == LastIdx);
    bus.o_vld   = w_vld;
    bus.o_last  = w_last;
    bus.o_data  = r_slot_data[r_rp][r_ecnt];
    bus.o_idx   = r_slot_idx[r_rp][r_ecnt];
    o_fill      = r_fill;
    o_ovf       = r_ovf;
  end

endmodule

// File: tb/tb_cm_sort_ser.sv
// Scoreboard bench for cm_sort_ser: expected elements are queued at stimulus time
// and compared against every valid output cycle.
module tb_cm_sort_ser;

  localparam int unsigned DCNT   = 4;
  localparam int unsigned DWIDTH = 16;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fill;
  logic       ovf;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  cm_sort_ser_if #(.DCNT(DCNT), .DWIDTH(DWIDTH)) bus ();

  cm_sort_ser #(.DCNT(DCNT), .DWIDTH(DWIDTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus    (bus),
    .o_fill (fill),
    .o_ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0][15:0] d, input logic [3:0][1:0] x, input bit push);
    exp_t e;
    bus.i_vld  = 1'b1;
    bus.i_data = d;
    bus.i_idx  = x;
    if (push) begin
      for (int i = 0; i < 4; i++) begin
        e.data = d[i];
        e.idx  = x[i];
        e.last = (i == 3);
        q.push_back(e);
      end
    end
  endtask

  task automatic send4(input int a0, input int a1, input int a2, input int a3,
                       input int x0, input int x1, input int x2, input int x3,
                       input bit push);
    logic [3:0][15:0] d;
    logic [3:0][1:0]  x;
    d[0] = 16'(a0); d[1] = 16'(a1); d[2] = 16'(a2); d[3] = 16'(a3);
    x[0] = 2'(x0);  x[1] = 2'(x1);  x[2] = 2'(x2);  x[3] = 2'(x3);
    drive(d, x, push);
    tick();
    bus.i_vld = 1'b0;
  endtask

  // Every valid cycle must show the queue head; a transfer pops it.
  always @(negedge clk) begin
    if (!rst && bus.o_vld) begin
      if (q.size() == 0) begin
        chk("unexpected_elem", 32'(bus.o_data), 32'hffff_ffff);
      end else begin
        chk("o_data", 32'(bus.o_data), 32'(q[0].data));
        chk("o_idx",  32'(bus.o_idx),  32'(q[0].idx));
        chk("o_last", 32'(bus.o_last), 32'(q[0].last));
        if (bus.i_rdy) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [3:0][15:0] d;
    logic [3:0][1:0]  x;
    logic [15:0]      td;
    logic [1:0]       tx;
    int               zeros_left;
    bit               ovf_seen;
    bit               rdy_pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    bus.i_vld  = 1'b0;
    bus.i_data = '0;
    bus.i_idx  = '0;
    bus.i_rdy  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_vld",  32'(bus.o_vld),  0);
    chk("rst_last", 32'(bus.o_last), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_ovf",  32'(ovf), 0);

    // Single vector
    bus.i_rdy = 1'b1;
    send4(3, 7, 9, 12, 2, 0, 3, 1, 1);
    chk("t1_vld", 32'(bus.o_vld), 1);
    chk("t1_fill", 32'(fill), 1);
    repeat (4) tick();
    chk("t1_vld_end", 32'(bus.o_vld), 0);
    chk("t1_fill_end", 32'(fill), 0);

    // Backpressure
    send4(3, 7, 9, 12, 2, 0, 3, 1, 1);
    for (int i = 0; i < 7; i++) begin
      bus.i_rdy = rdy_pat[i];
      tick();
    end
    chk("t2_vld_end", 32'(bus.o_vld), 0);
    chk("t2_drained", 32'(q.size()), 0);

    // Fill and overflow
    bus.i_rdy = 1'b0;
    send4(1, 2, 3, 4, 0, 1, 2, 3, 1);
    chk("t3_fill_a", 32'(fill), 1);
    send4(5, 6, 7, 8, 3, 2, 1, 0, 1);
    chk("t3_fill_b", 32'(fill), 2);
    chk("t3_ovf_b", 32'(ovf), 0);
    send4(9, 9, 9, 9, 0, 1, 2, 3, 0);
    chk("t3_fill_c", 32'(fill), 2);
    chk("t3_ovf_c", 32'(ovf), 1);
    tick();
    chk("t3_ovf_pulse", 32'(ovf), 0);
    bus.i_rdy = 1'b1;
    repeat (8) tick();
    chk("t3_vld_end", 32'(bus.o_vld), 0);
    chk("t3_drained", 32'(q.size()), 0);

    // Full with same-cycle release and capture
    send4(11, 12, 13, 14, 1, 0, 3, 2, 1);
    send4(21, 22, 23, 24, 2, 3, 0, 1, 1);
    tick();
    tick();
    chk("t4_fill_pre", 32'(fill), 2);
    chk("t4_last_pre", 32'(bus.o_last), 1);
    send4(31, 32, 33, 34, 0, 2, 1, 3, 1);
    chk("t4_fill_post", 32'(fill), 2);
    chk("t4_ovf", 32'(ovf), 0);
    repeat (12) tick();
    chk("t4_vld_end", 32'(bus.o_vld), 0);
    chk("t4_drained", 32'(q.size()), 0);

    // Reset mid-stream
    send4(51, 52, 53, 54, 3, 1, 0, 2, 1);
    tick();
    bus.i_rdy = 1'b0;
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
    bus.i_rdy = 1'b1;
    chk("t5_vld", 32'(bus.o_vld), 0);
    chk("t5_fill", 32'(fill), 0);
    send4(10, 20, 30, 40, 0, 1, 2, 3, 1);
    repeat (4) tick();
    chk("t5_drained", 32'(q.size()), 0);

    // Random sorted vectors, spacing 2*DCNT, ready mostly high
    ovf_seen = 1'b0;
    for (int v = 0; v < 20; v++) begin
      zeros_left = 2;
      for (int c = 0; c < 2 * DCNT; c++) begin
        if (c == 0) begin
          for (int i = 0; i < 4; i++) begin
            d[i] = 16'($urandom_range(0, 65535));
            x[i] = 2'(i);
          end
          for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 3 - p; j++) begin
              if (d[j] > d[j+1]) begin
                td = d[j]; d[j] = d[j+1]; d[j+1] = td;
                tx = x[j]; x[j] = x[j+1]; x[j+1] = tx;
              end
            end
          end
          drive(d, x, 1);
        end
        bus.i_rdy = ($urandom_range(0, 3) != 0) || (zeros_left == 0);
        if (!bus.i_rdy) zeros_left--;
        tick();
        bus.i_vld = 1'b0;
        if (ovf) ovf_seen = 1'b1;
      end
    end
    bus.i_rdy = 1'b1;
    repeat (3 * DCNT) begin
      tick();
      if (ovf) ovf_seen = 1'b1;
    end
    chk("t6_no_ovf", 32'(ovf_seen), 0);
    chk("t6_drained", 32'(q.size()), 0);
    chk("t6_vld_end", 32'(bus.o_vld), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cm_sort_ser.md
# cm_sort_ser

Vector-to-stream serializer placed directly downstream of `cm_sort`. It captures each sorted vector (`o_vld`/`o_data`/`o_idx` of `cm_sort`) into a two-slot vector buffer. It replays the vector one element per transfer on a valid/ready stream, ascending element order, marking the final element with `o_last`. `cm_sort` has no backpressure, so this block absorbs up to two pending vectors and flags any vector it must drop.

## Interface

Parameters:
- `DCNT`, 4, elements per vector; legal range ≥ 2; must match the upstream `cm_sort`.
- `DWIDTH`, 16, element width in bits.
- `IDX_WIDTH`, `sclog2(DCNT)`, index width; derived, not overridden.

Ports:
- `i_clk`  in  1  clock; single clock domain, all logic on the rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_vld`  in  1  sorted vector valid; single-cycle pulse from `cm_sort` `o_vld`.
- `i_data`  in  `[DCNT][DWIDTH]`  sorted data vector; element 0 is the smallest.
- `i_idx`  in  `[DCNT][IDX_WIDTH]`  original index of each sorted element.
- `o_vld`  out  1  stream element valid.
- `i_rdy`  in  1  downstream ready.
- `o_data`  out  `DWIDTH`  current element.
- `o_idx`  out  `IDX_WIDTH`  original index of the current element.
- `o_last`  out  1  current element is element `DCNT-1` of its vector.
- `o_fill`  out  2  number of buffered vectors, 0..2.
- `o_ovf`  out  1  one-cycle pulse: an input vector was dropped.

## Operation

State:
- Two vector slots, `slot[0..1]`, each holding data and idx.
- Write pointer `wp` (1 bit), read pointer `rp` (1 bit).
- Fill counter `fill` (0..2), which drives `o_fill`.
- Element counter `ecnt` (0..DCNT-1).
- The fill states are EMPTY (`fill`=0), ONE (`fill`=1) and FULL (`fill`=2).

Output path:
- `o_vld` = (`fill` != 0).
- `o_data` = `slot[rp].data[ecnt]`; `o_idx` = `slot[rp].idx[ecnt]`.
- `o_last` = `o_vld` & (`ecnt` == DCNT-1).

Transfer rules:
- A transfer occurs in any cycle with `o_vld` & `i_rdy`.
- Non-last transfer: `ecnt` increments.
- Last transfer (`o_last`): `ecnt` goes to 0, `rp` toggles, and the vector is released.

Capture rules:
- Capture: `i_vld` with (`fill` < 2) or (a release in the same cycle). The vector is written into `slot[wp]` and `wp` toggles.
- Drop: `i_vld` with `fill` == 2 and no release in the same cycle. The vector is discarded, no state changes, and `o_ovf` = 1 on the next cycle.

Fill update:
- `fill` increases by 1 on capture without release.
- `fill` decreases by 1 on release without capture.
- `fill` is unchanged when both or neither occur.

FULL with same-cycle release and capture:
- The released slot is the one being written (`wp` == `rp`).
- The write takes effect at the edge, so the next cycle reads the other slot; there is no hazard.

Output hold while stalled:
- While `o_vld` & !`i_rdy`, `o_data`, `o_idx` and `o_last` hold stable. No output changes until a transfer occurs.

Reset (`i_rst` = 1 at an edge):
- `fill`, `wp`, `rp` and `ecnt` go to 0.
- Next cycle: `o_vld` = 0, `o_last` = 0, `o_ovf` = 0, `o_fill` = 0.
- Slot contents are not reset. `o_data`/`o_idx` are don't-care while `o_vld` = 0.
- Reset mid-vector discards all buffered and partially sent vectors.
- `i_vld` in a reset cycle is ignored.

## Timing

- Latency: `i_vld` sampled at edge N into an EMPTY buffer gives `o_vld` = 1 with element 0 from cycle N+1.
- With `i_rdy` held at 1, a vector streams in exactly DCNT consecutive cycles.
- Back-to-back buffered vectors stream with no bubble between `o_last` and the next element 0.
- Sustained throughput is one vector per DCNT cycles. Faster `i_vld` arrival with `i_rdy` = 1 fills the buffer and eventually drops vectors.
- `o_ovf` is registered: it is high for exactly the cycle after the dropping `i_vld`.
- `o_vld`, `o_last` and `o_fill` are functions of registered state only; there is no combinational path from `i_rdy` or `i_vld`.

## Test plan

1. **Single vector.** DCNT=4, `i_rdy`=1, `i_vld` pulse with data {3,7,9,12}, idx {2,0,3,1}. Required: cycles N+1..N+4 give `o_data` 3,7,9,12 and `o_idx` 2,0,3,1. `o_last` is high only at N+4, `o_fill` goes 1→0 after N+4, and `o_vld` = 0 at N+5.
2. **Backpressure.** Same vector with `i_rdy` pattern 1,0,0,1,1,0,1. Required: each element is held stable while `i_rdy` = 0; the sequence is 3,7,9,12 with no duplicates or skips; `o_last` coincides with 12.
3. **Fill and overflow.** `i_rdy` = 0; vectors A={1,2,3,4}, B={5,6,7,8} and C={9,9,9,9} on three consecutive cycles. Required: `o_fill` reads 1, then 2, then stays 2; `o_ovf` is high for one cycle after C. Raising `i_rdy` then streams 1..8 in order, and C never appears.
4. **Full with simultaneous release and capture.** Buffer FULL (A streaming, B pending), A at `o_last` with `i_rdy` = 1, and vector C presented with `i_vld` in that same cycle. Required: C is accepted, `o_ovf` stays 0, `o_fill` stays 2, and the output order is A, B, C.
5. **Reset mid-stream.** After two elements of A are transferred, assert `i_rst` for one cycle. Required: next cycle `o_vld` = 0 and `o_fill` = 0. A fresh vector {10,20,30,40} then streams from 10, and `o_last` is on 40.
6. **Chained with `cm_sort`.** Connect to `cm_sort` (DCNT=6, REG_CNT=2) with 20 random vectors, `i_rdy` random at 75% high, and input spacing ≥ 2·DCNT cycles. Required: each streamed vector is ascending, matches a bubble-sort reference model, `o_idx` maps back to the original positions, and `o_ovf` never asserts.
